rc6_key_sched_ctrl: RTL
=======================

Name: rc6_key_sched_ctrl

Overview:
- Controller that sequences the RC6 key register through its full life cycle: restore the S table, load the user key, run the 132-step key expansion, then feed round subkeys to the cipher datapath.
- Contains the expansion arithmetic (A/B mixing and rotates) that drives the register's inSvalue/inLvalue.
- Handles the per-block subkey advance handshake with the round engine and scrubs the key after one block.
- Sits between the top-level command interface, the key register and the RC6 round datapath.

Parameters:
ROUNDS, 20, number of RC6 rounds; fixed by the 44-word S table (2*ROUNDS+4 = 44).
KEY_WORDS, 8, key length in 32-bit words (256-bit key); fixed by the 8-word L array.
EXP_STEPS, 132, expansion steps, 3*max(KEY_WORDS, 2*ROUNDS+4); derived, not overridable.

Ports:
inClk  input  1  clock
inResetN  input  1  asynchronous active-low reset
inKeyStart  input  1  single-cycle pulse: start a key load and expansion (key already present on the register's external key bus)
inAbort  input  1  single-cycle pulse: abandon current operation and scrub the key
inRoundReq  input  1  single-cycle pulse from datapath: current round finished, advance subkeys
inSregValue  input  32  register S[0] word
inLregValue  input  32  register L[0] word
inAdata  input  32  register A
inBdata  input  32  register B
outRegReset  output  1  drives register reset (active-high, synchronous)
outExtWr  output  1  drives register external key write
outIntWr  output  1  drives register internal expansion write
outKeyRd  output  1  drives register 64-bit subkey shift
outSvalue  output  32  new S/A value
outLvalue  output  32  new L/B value
outBusy  output  1  CLEAR, LOAD or EXPAND active
outKeyReady  output  1  subkeys valid for the datapath
outRoundIdx  output  5  subkey pairs consumed (0..ROUNDS)
outBlockDone  output  1  one-cycle pulse after the last advance

Behaviour:
- Reset values: all outputs 0; state IDLE; step counter and round counter 0.
- States: IDLE, CLEAR, LOAD, EXPAND, READY, DONE.
- IDLE -> CLEAR on inKeyStart.
- CLEAR: outRegReset=1 for 1 cycle, restoring the P/Q S table and zeroing L/A/B. Then -> LOAD.
- LOAD: outExtWr=1 for 1 cycle. Then -> EXPAND with step counter 0.
- EXPAND: outIntWr=1 on every cycle for exactly EXP_STEPS cycles.
  - outSvalue = Anew = rotl(inSregValue + inAdata + inBdata, 3).
  - outLvalue = rotl(inLregValue + Anew + inBdata, (Anew + inBdata)[4:0]).
  - All adds are modulo 2^32; the datapath is combinational from the register outputs.
  - After step 131 -> READY. The S table is then realigned (132 mod 44 = 0).
- outSvalue/outLvalue are 0 whenever outIntWr=0.
- Latency: inKeyStart sampled at cycle N gives outKeyReady=1 at cycle N+135 (1 CLEAR + 1 LOAD + 132 EXPAND + 1 registered). outBusy is high for cycles N+1..N+134.
- READY: outKeyReady=1.
  - Each inRoundReq produces outKeyRd=1 on the next cycle and increments outRoundIdx.
  - When the ROUNDS-th advance issues, -> DONE. Post-whitening S[42]/S[43] are now on the register's key0/key1 outputs.
- DONE: outBlockDone=1 for 1 cycle, outKeyReady=1 during that cycle, then -> IDLE with outKeyReady=0 and outRoundIdx cleared. The key has been scrubbed by the shifts; a new inKeyStart is required for the next block.
- inKeyStart while in CLEAR, LOAD or EXPAND: ignored.
- inKeyStart in READY: treated as a rekey; -> CLEAR and outRoundIdx cleared.
- inRoundReq outside READY: ignored, with no outKeyRd.
- At most one outKeyRd per cycle; a back-to-back inRoundReq on consecutive cycles is accepted every cycle.
- inAbort in any non-IDLE state: -> CLEAR, then IDLE (not LOAD), so the register is scrubbed.
  - inAbort has priority over inKeyStart and inRoundReq in the same cycle.
- inAbort in IDLE: ignored.
- Asynchronous reset mid-EXPAND: all outputs 0 immediately; the register contents are undefined until the next inKeyStart.
- outIntWr, outExtWr, outKeyRd and outRegReset are mutually exclusive in every cycle.

Decomposition:
- Shared package: ROUNDS, KEY_WORDS, EXP_STEPS, the state encoding, and P32/Q32 constants for benches.
- One sub-module, rc6_key_mix: combinational Anew/Bnew computation including the variable rotate. It is reusable by the round datapath's data-dependent rotate.

Test Plan:
- All-zero key, inKeyStart -> first EXPAND cycle: outSvalue=0xBF0A8B1D, outLvalue=0xB7E15163; outIntWr high exactly 132 cycles; outKeyReady at start+135.
- All-zero key expansion, then S table dumped via the register -> matches the software RC6 key schedule; full encryption of zero plaintext gives 8f5fbd0510d15fa893fa3fda6e857ec2.
- READY, 20 inRoundReq pulses -> 20 outKeyRd pulses one cycle later; outRoundIdx 1..20; outBlockDone once; outKeyReady drops afterwards.
- inAbort at EXPAND step 60 -> one outRegReset cycle, then IDLE; no further outIntWr; outKeyReady stays 0.
- inKeyStart and inRoundReq during EXPAND -> ignored; step count still 132; no outKeyRd.
- inResetN low mid-READY -> all outputs 0 asynchronously; after release, inRoundReq produces no outKeyRd.

Source files
------------

// File: rtl/rc6_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and rotate helper for the RC6 key schedule controller.
package rc6_key_sched_ctrl_pkg;

   localparam int ROUNDS    = 20;
   localparam int KEY_WORDS = 8;
   localparam int S_WORDS   = 2 * ROUNDS + 4;
   localparam int EXP_STEPS = 3 * ((KEY_WORDS > S_WORDS) ? KEY_WORDS : S_WORDS);
   localparam int STEP_W    = $clog2(EXP_STEPS);
   localparam int RIDX_W    = 5;

   localparam logic [31:0] P32 = 32'hB7E1_5163;
   localparam logic [31:0] Q32 = 32'h9E37_79B9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_EXPAND,
      ST_READY,
      ST_DONE
   } ks_state_e;

   // A shift by 32 yields zero, so sh == 0 returns x unchanged.
   function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
      return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
   endfunction

endpackage

// File: rtl/rc6_key_mix.sv
// One RC6 key-expansion mixing step: new A/S word and new B/L word with data-dependent rotate.
module rc6_key_mix
   import rc6_key_sched_ctrl_pkg::*;
(
   input  logic [31:0] s_i,
   input  logic [31:0] l_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] a_new_o,
   output logic [31:0] b_new_o
);

   logic [31:0] ab_sum;

   assign a_new_o = rotl32(s_i + a_i + b_i, 5'd3);
   assign ab_sum  = a_new_o + b_i;
   assign b_new_o = rotl32(l_i + ab_sum, ab_sum[4:0]);

endmodule

// File: rtl/rc6_key_sched_ctrl.sv
// Sequences the RC6 key register: clear, load, 132-step expansion, then per-round subkey advance.
module rc6_key_sched_ctrl
   import rc6_key_sched_ctrl_pkg::*;
(
   input  logic              inClk,
   input  logic              inResetN,
   input  logic              inKeyStart,
   input  logic              inAbort,
   input  logic              inRoundReq,
   input  logic [31:0]       inSregValue,
   input  logic [31:0]       inLregValue,
   input  logic [31:0]       inAdata,
   input  logic [31:0]       inBdata,
   output logic              outRegReset,
   output logic              outExtWr,
   output logic              outIntWr,
   output logic              outKeyRd,
   output logic [31:0]       outSvalue,
   output logic [31:0]       outLvalue,
   output logic              outBusy,
   output logic              outKeyReady,
   output logic [RIDX_W-1:0] outRoundIdx,
   output logic              outBlockDone
);

   ks_state_e         state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [RIDX_W-1:0] round_q, round_d;
   logic              abort_q, abort_d;
   logic              key_rd_q, key_rd_d;
   logic [31:0]       a_new, b_new;

   rc6_key_mix u_mix (
      .s_i     (inSregValue),
      .l_i     (inLregValue),
      .a_i     (inAdata),
      .b_i     (inBdata),
      .a_new_o (a_new),
      .b_new_o (b_new)
   );

   always_ff @(posedge inClk or negedge inResetN) begin
      if (!inResetN) begin
         state_q  <= ST_IDLE;
         step_q   <= '0;
         round_q  <= '0;
         abort_q  <= 1'b0;
         key_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         round_q  <= round_d;
         abort_q  <= abort_d;
         key_rd_q <= key_rd_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      round_d  = round_q;
      abort_d  = abort_q;
      key_rd_d = 1'b0;
      // abort_q steers the scrub cycle back to IDLE instead of on to LOAD
      if (inAbort && (state_q != ST_IDLE)) begin
         state_d = ST_CLEAR;
         abort_d = 1'b1;
         step_d  = '0;
         round_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inKeyStart) begin
                  state_d = ST_CLEAR;
                  abort_d = 1'b0;
                  round_d = '0;
               end
            end
            ST_CLEAR: begin
               state_d = abort_q ? ST_IDLE : ST_LOAD;
               abort_d = 1'b0;
            end
            ST_LOAD: begin
               state_d = ST_EXPAND;
               step_d  = '0;
            end
            ST_EXPAND: begin
               if (step_q == STEP_W'(EXP_STEPS - 1)) begin
                  state_d = ST_READY;
                  step_d  = '0;
               end else begin
                  step_d = step_q + 1'b1;
               end
            end
            ST_READY: begin
               // a rekey wins over an advance so the shift never overlaps the clear
               if (inKeyStart) begin
                  state_d = ST_CLEAR;
                  abort_d = 1'b0;
                  round_d = '0;
               end else if (inRoundReq) begin
                  key_rd_d = 1'b1;
                  round_d  = round_q + 1'b1;
                  if (round_q == RIDX_W'(ROUNDS - 1)) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               round_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign outRegReset  = (state_q == ST_CLEAR);
   assign outExtWr     = (state_q == ST_LOAD);
   assign outIntWr     = (state_q == ST_EXPAND);
   assign outKeyRd     = key_rd_q;
   assign outSvalue    = outIntWr ? a_new : 32'd0;
   assign outLvalue    = outIntWr ? b_new : 32'd0;
   assign outBusy      = outRegReset | outExtWr | outIntWr;
   assign outKeyReady  = (state_q == ST_READY) || (state_q == ST_DONE);
   assign outRoundIdx  = round_q;
   assign outBlockDone = (state_q == ST_DONE);

endmodule
